// File: rtl/radio_tx_timed_player.sv
// Timed TX sample player: drains an AXI-Stream of sample packets into the radio DAC strobe port.
// Latency: DAC word and event pulse appear one cycle after the consuming or causing cycle.
// Backpressure: s_axis_tready follows radio_tx_stb while playing, is gated by the start time while waiting, and is always high while flushing.
module radio_tx_timed_player #(
    parameter int ITEM_W = 32,
    parameter int NIPC   = 1
) (
    input  logic                     radio_clk,
    input  logic                     radio_rst_n,
    input  logic [63:0]              radio_time,
    input  logic                     radio_tx_stb,
    output logic [ITEM_W*NIPC-1:0]   radio_tx_data,
    output logic                     tx_running,
    input  logic [ITEM_W*NIPC-1:0]   s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [63:0]              s_axis_ttime,
    input  logic                     s_axis_thas_time,
    input  logic                     s_axis_teob,
    output logic                     err_stb,
    output logic [1:0]               err_code,
    output logic [63:0]              err_time
);

    localparam int W = ITEM_W * NIPC;

    localparam logic [1:0] EV_UNDERRUN = 2'd1;
    localparam logic [1:0] EV_LATE     = 2'd2;
    localparam logic [1:0] EV_EOB_ACK  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TIME,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    ts_q, ts_d;
    logic [W-1:0]   data_q, data_d;
    logic           running_q;
    logic           err_stb_q;
    logic [1:0]     err_code_q;
    logic [63:0]    err_time_q;
    logic           ev_vld;
    logic [1:0]     ev_code;
    logic           tready;
    logic           eob_word;

    assign eob_word = s_axis_tvalid && s_axis_tlast && s_axis_teob;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        data_d  = data_q;
        ev_vld  = 1'b0;
        ev_code = 2'd0;
        tready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    if (!s_axis_thas_time) begin
                        state_d = S_RUN;
                    end else if (s_axis_ttime > radio_time) begin
                        ts_d    = s_axis_ttime;
                        state_d = S_WAIT_TIME;
                    end else begin
                        ev_vld  = 1'b1;
                        ev_code = EV_LATE;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_WAIT_TIME: begin
                tready = radio_tx_stb && (radio_time == ts_q);
                if (tready) begin
                    data_d = s_axis_tvalid ? s_axis_tdata : '0;
                    // A single-word burst can complete on its very first strobe.
                    if (eob_word) begin
                        ev_vld  = 1'b1;
                        ev_code = EV_EOB_ACK;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (radio_time > ts_q) begin
                    ev_vld  = 1'b1;
                    ev_code = EV_LATE;
                    state_d = S_FLUSH;
                end
            end
            S_RUN: begin
                tready = radio_tx_stb;
                if (radio_tx_stb) begin
                    if (s_axis_tvalid) begin
                        data_d = s_axis_tdata;
                        if (s_axis_tlast && s_axis_teob) begin
                            ev_vld  = 1'b1;
                            ev_code = EV_EOB_ACK;
                            state_d = S_IDLE;
                        end
                    end else begin
                        data_d  = '0;
                        ev_vld  = 1'b1;
                        ev_code = EV_UNDERRUN;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                tready = 1'b1;
                if (eob_word) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            data_q     <= '0;
            running_q  <= 1'b0;
            err_stb_q  <= 1'b0;
            err_code_q <= 2'd0;
            err_time_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            data_q     <= data_d;
            running_q  <= (state_d == S_RUN);
            err_stb_q  <= ev_vld;
            if (ev_vld) begin
                err_code_q <= ev_code;
                err_time_q <= radio_time;
            end
        end
    end

    assign s_axis_tready = tready;
    assign radio_tx_data = data_q;
    assign tx_running    = running_q;
    assign err_stb       = err_stb_q;
    assign err_code      = err_code_q;
    assign err_time      = err_time_q;

endmodule

// File: tb/tb_radio_tx_timed_player.sv
// Scenario bench for radio_tx_timed_player: expected DAC words and events are queued as
// stimulus is driven and popped when the DUT produces them.
module tb_radio_tx_timed_player;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   radio_time = '0;
    logic          radio_tx_stb = 1'b0;
    logic [31:0]   radio_tx_data;
    logic          tx_running;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [63:0]   s_axis_ttime = '0;
    logic          s_axis_thas_time = 1'b0;
    logic          s_axis_teob = 1'b0;
    logic          err_stb;
    logic [1:0]    err_code;
    logic [63:0]   err_time;

    int            nvec = 0;
    int            nfail = 0;
    logic [31:0]   last_dac = '0;
    logic [31:0]   exp_dat[$];
    logic [1:0]    exp_code[$];
    logic [63:0]   exp_time[$];

    always #5 clk = ~clk;

    radio_tx_timed_player dut (
        .radio_clk        (clk),
        .radio_rst_n      (rst_n),
        .radio_time       (radio_time),
        .radio_tx_stb     (radio_tx_stb),
        .radio_tx_data    (radio_tx_data),
        .tx_running       (tx_running),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_ttime     (s_axis_ttime),
        .s_axis_thas_time (s_axis_thas_time),
        .s_axis_teob      (s_axis_teob),
        .err_stb          (err_stb),
        .err_code         (err_code),
        .err_time         (err_time)
    );

    // One radio cycle: observe any event pulse, then advance the radio clock counter.
    task automatic tick();
        logic [1:0]  c;
        logic [63:0] t;
        @(posedge clk);
        #1;
        if (err_stb) begin
            nvec++;
            if (exp_code.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_event: code=%0d time=%0d, none expected", err_code, err_time);
            end else begin
                c = exp_code.pop_front();
                t = exp_time.pop_front();
                if (err_code !== c || err_time !== t) begin
                    nfail++;
                    $display("FAIL event: code=%0d time=%0d, expected code=%0d time=%0d",
                             err_code, err_time, c, t);
                end
            end
        end
        radio_time = radio_time + 64'd1;
    endtask

    task automatic push_event(input logic [1:0] c, input logic [63:0] t);
        exp_code.push_back(c);
        exp_time.push_back(t);
    endtask

    task automatic check_events_drained(input string name);
        nvec++;
        if (exp_code.size() != 0) begin
            nfail++;
            $display("FAIL %s_missing_event: %0d events outstanding, expected 0", name, exp_code.size());
            exp_code.delete();
            exp_time.delete();
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic eob,
                             input logic has_t, input logic [63:0] ts,
                             input bit consumed, input int max_wait, input bit ack);
        int waited;
        logic [31:0] exp;
        waited = 0;
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_teob = eob;
        s_axis_thas_time = has_t;
        s_axis_ttime = ts;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        nvec++;
        if (!s_axis_tready) begin
            nfail++;
            $display("FAIL handshake_timeout: word %h not accepted within %0d cycles", d, waited);
            return;
        end else if (waited > max_wait) begin
            nfail++;
            $display("FAIL handshake_gap: word %h waited %0d cycles, expected at most %0d", d, waited, max_wait);
        end
        if (consumed) exp_dat.push_back(d);
        if (ack) push_event(2'd3, radio_time);
        tick();
        nvec++;
        if (consumed) begin
            exp = exp_dat.pop_front();
            last_dac = exp;
        end
        if (radio_tx_data !== last_dac) begin
            nfail++;
            $display("FAIL dac_data: got %h, expected %h", radio_tx_data, last_dac);
        end
    endtask

    task automatic check_running(input string name, input logic exp);
        nvec++;
        if (tx_running !== exp) begin
            nfail++;
            $display("FAIL %s_tx_running: got %b, expected %b", name, tx_running, exp);
        end
    endtask

    // Untimed burst, every word played, EOB on the final word.
    task automatic play_burst(input int npkt, input int nwords, input logic [31:0] base);
        int k;
        k = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int w = 0; w < nwords; w++) begin
                send_word(base + 32'(k), w == nwords - 1, (p == npkt - 1) && (w == nwords - 1),
                          1'b0, 64'd0, 1'b1, (k == 0) ? 1 : 0,
                          (p == npkt - 1) && (w == nwords - 1));
                if (k == 0) check_running("burst_start", 1'b1);
                k++;
            end
        end
        s_axis_tvalid = 1'b0;
        check_running("burst_end", 1'b0);
    endtask

    task automatic test_reset();
        s_axis_tvalid = 1'b1;
        radio_tx_stb = 1'b1;
        #3;
        nvec++;
        if ({radio_tx_data, tx_running, s_axis_tready, err_stb, err_code, err_time} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: data=%h run=%b rdy=%b stb=%b code=%0d time=%0d, expected all zero",
                     radio_tx_data, tx_running, s_axis_tready, err_stb, err_code, err_time);
        end
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        radio_tx_stb = 1'b1;
        play_burst(3, 4, 32'h1000_0000);
        tick();
        check_events_drained("back_to_back");
    endtask

    task automatic test_timed_start();
        int n;
        n = 0;
        radio_time = 64'd900;
        radio_tx_stb = 1'b1;
        s_axis_tdata = 32'hA000_0000;
        s_axis_tlast = 1'b0;
        s_axis_teob = 1'b0;
        s_axis_thas_time = 1'b1;
        s_axis_ttime = 64'd1000;
        s_axis_tvalid = 1'b1;
        #1;
        while (radio_time != 64'd1000 && n < 300) begin
            nvec++;
            if (s_axis_tready !== 1'b0) begin
                nfail++;
                $display("FAIL timed_early_ready: tready=%b at time %0d, expected 0", s_axis_tready, radio_time);
            end
            tick();
            #1;
            n++;
        end
        nvec++;
        if (s_axis_tready !== 1'b1) begin
            nfail++;
            $display("FAIL timed_start_ready: tready=%b at time %0d, expected 1", s_axis_tready, radio_time);
        end
        send_word(32'hA000_0000, 1'b0, 1'b0, 1'b1, 64'd1000, 1'b1, 0, 1'b0);
        check_running("timed_run", 1'b1);
        send_word(32'hA000_0001, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 0, 1'b0);
        send_word(32'hA000_0002, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 0, 1'b0);
        send_word(32'hA000_0003, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 0, 1'b1);
        s_axis_tvalid = 1'b0;
        tick();
        check_events_drained("timed_start");
    endtask

    task automatic test_late_packet();
        radio_time = 64'd100;
        push_event(2'd2, 64'd100);
        send_word(32'hB000_0000, 1'b0, 1'b0, 1'b1, 64'd50, 1'b0, 1, 1'b0);
        check_running("late", 1'b0);
        send_word(32'hB000_0001, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        send_word(32'hB000_0002, 1'b0, 1'b0, 1'b1, 64'd60, 1'b0, 0, 1'b0);
        send_word(32'hB000_0003, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        check_events_drained("late");
    endtask

    task automatic test_underrun();
        send_word(32'hC000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1, 1'b0);
        send_word(32'hC000_0001, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 0, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        push_event(2'd1, radio_time);
        tick();
        nvec++;
        if (radio_tx_data !== 32'd0) begin
            nfail++;
            $display("FAIL underrun_zero: got %h, expected 0", radio_tx_data);
        end
        last_dac = 32'd0;
        send_word(32'hC000_0002, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        send_word(32'hC000_0003, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        for (int w = 0; w < 4; w++)
            send_word(32'hC100_0000 + 32'(w), w == 3, w == 3, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        play_burst(1, 4, 32'hC200_0000);
        tick();
        check_events_drained("underrun");
    endtask

    task automatic test_missed_start();
        int n;
        n = 0;
        radio_tx_stb = 1'b0;
        radio_time = 64'd190;
        s_axis_tdata = 32'hD000_0000;
        s_axis_tlast = 1'b0;
        s_axis_teob = 1'b0;
        s_axis_thas_time = 1'b1;
        s_axis_ttime = 64'd200;
        s_axis_tvalid = 1'b1;
        #1;
        while (radio_time != 64'd201 && n < 100) begin
            nvec++;
            if (s_axis_tready !== 1'b0) begin
                nfail++;
                $display("FAIL missed_ready: tready=%b at time %0d, expected 0", s_axis_tready, radio_time);
            end
            tick();
            #1;
            n++;
        end
        push_event(2'd2, 64'd201);
        tick();
        radio_tx_stb = 1'b1;
        send_word(32'hD000_0000, 1'b0, 1'b0, 1'b1, 64'd200, 1'b0, 0, 1'b0);
        send_word(32'hD000_0001, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        send_word(32'hD000_0002, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 0, 1'b0);
        s_axis_tvalid = 1'b0;
        tick();
        check_events_drained("missed_start");
    endtask

    task automatic test_reset_mid_run();
        send_word(32'hE000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1, 1'b0);
        send_word(32'hE000_0001, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 0, 1'b0);
        check_running("pre_reset", 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({radio_tx_data, tx_running, s_axis_tready, err_stb, err_code, err_time} !== '0) begin
            nfail++;
            $display("FAIL midrun_reset_outputs: data=%h run=%b rdy=%b stb=%b code=%0d time=%0d, expected all zero",
                     radio_tx_data, tx_running, s_axis_tready, err_stb, err_code, err_time);
        end
        s_axis_tvalid = 1'b0;
        last_dac = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        play_burst(2, 3, 32'hE100_0000);
        tick();
        check_events_drained("reset_mid_run");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_timed_start();
        test_late_packet();
        test_underrun();
        test_missed_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
